// File: rtl/nv_sync_pkg.sv
// Shared constants and helpers for the multi-bit level synchronizer family.
package nv_sync_pkg;

    localparam int STAGES_MIN = 2;
    localparam int STAGES_MAX = 4;
    localparam int FILTER_MAX = 15;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/syncnd_c_bus_ppp_chain.sv
// Single-bit synchronizer chain; kept as its own cell so a library sync cell can replace it.
module syncnd_c_chain
    import nv_sync_pkg::*;
#(
    parameter int   STAGES    = 3,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic sy
);

    if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
        $error("syncnd_c_chain: STAGES must be within 2..4");
    end

    // Pure flop-to-flop chain; attributes keep tools from retiming or merging it.
    (* ASYNC_REG = "TRUE", dont_touch = "true" *) logic [STAGES-1:0] s_q;
    logic [STAGES-1:0] s_d;

    always_comb begin
        s_d = {s_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            s_q <= {STAGES{RESET_VAL}};
        end else begin
            s_q <= s_d;
        end
    end

    assign sy = s_q[STAGES-1];

endmodule

// File: rtl/syncnd_c_bus_ppp.sv
// WIDTH independent level synchronizers with optional stability filter and edge pulses.
module syncnd_c_bus_ppp
    import nv_sync_pkg::*;
#(
    parameter int               WIDTH     = 1,
    parameter int               STAGES    = 3,
    parameter int               FILTER    = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_rise,
    output logic [WIDTH-1:0] q_fall,
    output logic             q_chg
);

    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $error("syncnd_c_bus_ppp: WIDTH must be within 1..64");
    end
    if (FILTER < 0 || FILTER > FILTER_MAX) begin : g_bad_filter
        $error("syncnd_c_bus_ppp: FILTER must be within 0..15");
    end

    logic [WIDTH-1:0] sy;
    logic [WIDTH-1:0] q_prev_q;
    logic [WIDTH-1:0] q_prev_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        syncnd_c_chain #(
            .STAGES    (STAGES),
            .RESET_VAL (RESET_VAL[i])
        ) u_chain (
            .clk (clk),
            .clr (clr),
            .d   (d[i]),
            .sy  (sy[i])
        );
    end

    if (FILTER == 0) begin : g_bypass
        assign q = sy;
    end else begin : g_filter
        localparam int CNT_W = (clog2(FILTER + 1) > 1) ? clog2(FILTER + 1) : 1;
        localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER - 1);

        logic [CNT_W-1:0] cnt_q [WIDTH];
        logic [CNT_W-1:0] cnt_d [WIDTH];
        logic [WIDTH-1:0] filt_q;
        logic [WIDTH-1:0] filt_d;

        // Counter only runs while sy disagrees with q, so it never exceeds FILTER-1.
        always_comb begin
            filt_d = filt_q;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_d[i] = '0;
                if (sy[i] != filt_q[i]) begin
                    if (cnt_q[i] == CNT_LAST) begin
                        filt_d[i] = sy[i];
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
            end
        end

        always_ff @(posedge clk or posedge clr) begin
            if (clr) begin
                filt_q <= RESET_VAL;
                for (int i = 0; i < WIDTH; i++) begin
                    cnt_q[i] <= '0;
                end
            end else begin
                filt_q <= filt_d;
                for (int i = 0; i < WIDTH; i++) begin
                    cnt_q[i] <= cnt_d[i];
                end
            end
        end

        assign q = filt_q;
    end

    always_comb begin
        q_prev_d = q;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q_prev_q <= RESET_VAL;
        end else begin
            q_prev_q <= q_prev_d;
        end
    end

    assign q_rise = q & ~q_prev_q;
    assign q_fall = ~q & q_prev_q;
    assign q_chg  = |(q_rise | q_fall);

endmodule

// File: tb/tb_syncnd_c_bus_ppp.sv
// Directed checks on fixed configurations plus a randomized sweep against a windowed reference model.
module tb_syncnd_c_bus_ppp;

    logic clk;
    logic clr_d, clr_c, clr_sw;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ua: held input equal to a mixed reset value
    logic [3:0] da, a_q, a_r, a_f;
    logic       a_c;
    syncnd_c_bus_ppp #(.WIDTH(4), .STAGES(3), .FILTER(0), .RESET_VAL(4'b0101)) ua (
        .clk(clk), .clr(clr_d), .d(da), .q(a_q), .q_rise(a_r), .q_fall(a_f), .q_chg(a_c));

    // ud: 8-bit bypass, latency and simultaneous edges
    logic [7:0] dd, d_q, d_r, d_f;
    logic       d_c;
    syncnd_c_bus_ppp #(.WIDTH(8), .STAGES(3), .FILTER(0), .RESET_VAL(8'h00)) ud (
        .clk(clk), .clr(clr_d), .d(dd), .q(d_q), .q_rise(d_r), .q_fall(d_f), .q_chg(d_c));

    // ub: filter of 3
    logic [3:0] db, b_q, b_r, b_f;
    logic       b_c;
    syncnd_c_bus_ppp #(.WIDTH(4), .STAGES(3), .FILTER(3), .RESET_VAL(4'b0000)) ub (
        .clk(clk), .clr(clr_d), .d(db), .q(b_q), .q_rise(b_r), .q_fall(b_f), .q_chg(b_c));

    // uc: filter of 4, cleared mid-count
    logic [3:0] dc, c_q, c_r, c_f;
    logic       c_c;
    syncnd_c_bus_ppp #(.WIDTH(4), .STAGES(3), .FILTER(4), .RESET_VAL(4'b1010)) uc (
        .clk(clk), .clr(clr_c), .d(dc), .q(c_q), .q_rise(c_r), .q_fall(c_f), .q_chg(c_c));

    // Sweep: STAGES in {2,4} x FILTER in {0,1,15}, all fed the same random input.
    localparam logic [3:0] SW_RV = 4'b0110;
    logic [3:0] d_sw;

    for (genvar g = 0; g < 6; g++) begin : g_sw
        localparam int ST = (g < 3) ? 2 : 4;
        localparam int FI = (g % 3 == 0) ? 0 : ((g % 3 == 1) ? 1 : 15);

        logic [3:0] s_q, s_r, s_f;
        logic       s_c;
        syncnd_c_bus_ppp #(.WIDTH(4), .STAGES(ST), .FILTER(FI), .RESET_VAL(SW_RV)) u_sw (
            .clk(clk), .clr(clr_sw), .d(d_sw), .q(s_q), .q_rise(s_r), .q_fall(s_f), .q_chg(s_c));

        // hist[0] is the input sampled at the latest edge
        logic [3:0] hist [$];
        logic [3:0] m_q, m_prev;

        function automatic logic [3:0] sy_ago(input int j);
            if (hist.size() > ST - 1 + j) return hist[ST-1+j];
            return SW_RV;
        endfunction

        // q takes a new value once the synchronized input has shown that value,
        // different from q, over the last FI evaluated cycles.
        always @(posedge clk or posedge clr_sw) begin
            if (clr_sw) begin
                hist.delete();
                m_q    = SW_RV;
                m_prev = SW_RV;
            end else begin
                hist.push_front(d_sw);
                if (hist.size() > ST + FI + 1) void'(hist.pop_back());
                m_prev = m_q;
                if (FI == 0) begin
                    m_q = sy_ago(0);
                end else begin
                    for (int b = 0; b < 4; b++) begin
                        logic [3:0] w;
                        logic       all_new;
                        all_new = 1'b1;
                        for (int j = 1; j <= FI; j++) begin
                            w = sy_ago(j);
                            if (w[b] == m_q[b]) all_new = 1'b0;
                        end
                        if (all_new) m_q[b] = ~m_q[b];
                    end
                end
            end
        end

        always @(negedge clk) begin
            if (!clr_sw) begin
                chk($sformatf("sw%0d_q", g), {4'b0, s_q}, {4'b0, m_q});
                chk($sformatf("sw%0d_rise", g), {4'b0, s_r}, {4'b0, m_q & ~m_prev});
                chk($sformatf("sw%0d_fall", g), {4'b0, s_f}, {4'b0, ~m_q & m_prev});
                chk($sformatf("sw%0d_chg", g), {7'b0, s_c}, {7'b0, (m_q != m_prev)});
                chk($sformatf("sw%0d_excl", g), {4'b0, s_r & s_f}, 8'h00);
            end
        end
    end

    initial begin
        clr_d  = 1'b1;
        clr_c  = 1'b1;
        clr_sw = 1'b1;
        da     = 4'b0101;
        dd     = 8'h00;
        db     = 4'b0000;
        dc     = 4'b0101;
        d_sw   = SW_RV;
        #2;
        chk("clr_a_q", {4'b0, a_q}, 8'h05);
        chk("clr_a_pulse", {a_c, 3'b0, a_r | a_f}, 8'h00);
        chk("clr_c_q", {4'b0, c_q}, 8'h0A);
        chk("clr_d_q", d_q, 8'h00);

        tick();
        clr_d = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rel_a_q", {4'b0, a_q}, 8'h05);
            chk("rel_a_pulse", {a_c, 3'b0, a_r | a_f}, 8'h00);
        end

        // bypass latency of STAGES edges
        dd = 8'h01;
        tick(); chk("lat_q1", d_q, 8'h00);
        tick(); chk("lat_q2", d_q, 8'h00);
        tick(); chk("lat_q3", d_q, 8'h01);
        chk("lat_rise", d_r, 8'h01);
        chk("lat_chg", {7'b0, d_c}, 8'h01);
        tick(); chk("lat_rise_end", d_r, 8'h00);
        chk("lat_chg_end", {7'b0, d_c}, 8'h00);
        dd = 8'h00;
        tick(); tick(); tick();
        chk("lat_fall", d_f, 8'h01);
        tick(); chk("lat_fall_end", {d_c, 7'b0} | d_f, 8'h00);

        // simultaneous bits
        dd = 8'hF0;
        tick(); tick(); chk("sim_pre", d_q, 8'h00);
        tick();
        chk("sim_rise", d_r, 8'hF0);
        chk("sim_fall", d_f, 8'h00);
        chk("sim_chg", {7'b0, d_c}, 8'h01);
        tick(); chk("sim_chg_end", {7'b0, d_c}, 8'h00);
        dd = 8'h0F;
        tick(); tick(); tick();
        chk("swap_rise", d_r, 8'h0F);
        chk("swap_fall", d_f, 8'hF0);
        chk("swap_chg", {7'b0, d_c}, 8'h01);
        tick(); chk("swap_chg_end", {7'b0, d_c}, 8'h00);

        // filter rejects a 2-cycle pulse
        db = 4'b0010;
        tick(); tick();
        db = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("rej_q", {4'b0, b_q}, 8'h00);
            chk("rej_pulse", {b_c, 3'b0, b_r | b_f}, 8'h00);
        end
        // filter accepts after STAGES+FILTER edges
        db = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("acc_wait", {4'b0, b_q}, 8'h00);
        end
        tick();
        chk("acc_q", {4'b0, b_q}, 8'h02);
        chk("acc_rise", {4'b0, b_r}, 8'h02);
        tick();
        chk("acc_rise_end", {4'b0, b_r}, 8'h00);
        chk("acc_hold", {4'b0, b_q}, 8'h02);

        // clear mid-count on the filter-4 instance
        clr_c = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("f4_wait", {4'b0, c_q}, 8'h0A);
        end
        tick();
        chk("f4_q", {4'b0, c_q}, 8'h05);
        chk("f4_rise", {4'b0, c_r}, 8'h05);
        chk("f4_fall", {4'b0, c_f}, 8'h0A);
        dc = 4'b1111;
        for (int i = 0; i < 5; i++) tick();
        chk("mid_pre", {4'b0, c_q}, 8'h05);
        clr_c = 1'b1;
        #1;
        chk("mid_clr_q", {4'b0, c_q}, 8'h0A);
        chk("mid_clr_pulse", {c_c, 3'b0, c_r | c_f}, 8'h00);
        tick(); tick();
        chk("mid_hold_q", {4'b0, c_q}, 8'h0A);
        clr_c = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("restart_wait", {4'b0, c_q}, 8'h0A);
            chk("restart_quiet", {7'b0, c_c}, 8'h00);
        end
        tick();
        chk("restart_q", {4'b0, c_q}, 8'h0F);
        chk("restart_rise", {4'b0, c_r}, 8'h05);
        chk("restart_fall", {4'b0, c_f}, 8'h00);

        // randomized sweep at random phase against the model
        tick();
        clr_sw = 1'b0;
        for (int step = 0; step < 300; step++) begin
            repeat ($urandom_range(1, 20)) @(posedge clk);
            #($urandom_range(1, 9));
            d_sw = 4'($urandom);
        end
        repeat (30) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
